param_deserializer: RTL and testbench
=====================================

PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 Parameter DATA_W, default 16: maximum word width in bits, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in the word MSB; 0 means it lands in the word LSB.
REQ-003 Parameter LEN_W, default $clog2(DATA_W)+1, derived and not overridden: width of all length fields.
REQ-004 clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 arstn_i  in  1  reset, asynchronous assert, active-low.
REQ-006 data_i  in  1  serial data bit.
REQ-007 data_val_i  in  1  data_i is valid this cycle.
REQ-008 data_len_i  in  LEN_W  target word length, sampled with the first bit of each word.
REQ-009 flush_i  in  1  emit the current partial word.
REQ-010 deser_data_o  out  DATA_W  parallel word, right-aligned, unused upper bits 0.
REQ-011 deser_len_o  out  LEN_W  number of valid bits in deser_data_o.
REQ-012 deser_data_val_o  out  1  output word valid.
REQ-013 deser_data_rdy_i  in  1  downstream accepts the word when high together with deser_data_val_o.
REQ-014 overflow_o  out  1  one-cycle pulse when a completed word is dropped.

Function
REQ-015 The FSM SHALL have two states, IDLE (bit count 0) and COLLECT (bit count 1..L-1).
- IDLE -> COLLECT on data_val_i.
- COLLECT -> IDLE when the L-th bit is accepted or on a flush.
REQ-016 In IDLE with data_val_i=1, L SHALL be latched from data_len_i; data_len_i=0 or data_len_i>DATA_W SHALL be treated as L=DATA_W.
REQ-017 data_len_i SHALL be ignored outside the first-bit cycle.
REQ-018 If L=1, the word SHALL complete on the first-bit cycle without entering COLLECT.
REQ-019 With MSB_FIRST=1, the shift register SHALL shift left with the new bit entering bit 0, so that the k-th of n bits ends at bit n-k.
REQ-020 With MSB_FIRST=0, bit k (k = 1..n) SHALL be written to index k-1.
REQ-021 A word SHALL complete on the edge that accepts the L-th bit.
- deser_data_o, deser_len_o=L and deser_data_val_o=1 are visible after that same edge (1-cycle latency).
- The next word's first bit is accepted in the following cycle with no bubble.
REQ-022 flush_i in COLLECT SHALL complete the partial word with deser_len_o equal to the bits collected.
- If data_val_i is also high, that bit is included before the flush.
REQ-023 flush_i in IDLE without data_val_i SHALL be ignored.
REQ-024 flush_i in IDLE with data_val_i SHALL emit a 1-bit word.
REQ-025 deser_data_val_o SHALL stay high, with data and length stable, until a cycle with deser_data_rdy_i=1, then deassert unless a new word completes in that same cycle.
REQ-026 A word completing while the output is valid and not being accepted that cycle SHALL be dropped; overflow_o pulses for one cycle and the output is unchanged.
REQ-027 A word completing in the same cycle as an acceptance SHALL be loaded; deser_data_val_o stays high.
REQ-028 After every completion (including a dropped one) the shift register SHALL clear to 0 and the count SHALL return to 0.

Reset
REQ-029 While arstn_i=0, the block SHALL immediately force all outputs to 0, the count and shift register to 0, and the state to IDLE.
REQ-030 A reset in mid-word SHALL discard the partial word with no output and no overflow_o.
REQ-031 The first edge after arstn_i rises SHALL accept data normally.

Structure
REQ-032 Package deser_pkg SHALL hold the FSM state enum typedef and a length-clamp function (raw length, DATA_W) -> effective L.
REQ-033 The output handshake register (valid/data/len hold, accept, overflow decision) SHALL be sub-module deser_out_stage, parametrised by DATA_W and LEN_W.

Verification
REQ-034 DATA_W=16, MSB_FIRST=1, len=0 (treated as 16), bits 1,0,1,1 then twelve 0s, rdy=1 -> deser_data_o=16'hB000, len=16, valid for 1 cycle after the 16th bit.
REQ-035 MSB_FIRST=0, len=4, bits 1,1,0,0 back-to-back twice -> two words 4'h3, len=4, on consecutive-word edges with no bubble.
REQ-036 MSB_FIRST=1, len=8, bits 1,0,1 then flush_i -> deser_data_o=16'h0005, len=3.
REQ-037 rdy=0, len=2, send four bits -> first word held, second dropped with overflow_o=1 for 1 cycle; rdy=1 in the completion cycle of the second word -> second word loaded, no overflow.
REQ-038 arstn_i pulsed low after 5 of 8 bits -> outputs 0 at once; a new 8-bit word afterwards is deserialised correctly.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and helpers for the parameterised serial-to-parallel deserializer.
package deser_pkg;

   // IDLE holds no collected bits; COLLECT holds between 1 and L-1 bits.
   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   // A requested length of zero, or one wider than the word, selects a full word.
   function automatic int unsigned clamp_len(input int unsigned raw_len,
                                             input int unsigned data_w);
      if (raw_len == 0 || raw_len > data_w) begin
         return data_w;
      end
      return raw_len;
   endfunction

endpackage

// File: rtl/deser_out_stage.sv
// Output handshake register: holds a completed word until downstream takes it,
// and drops (with an overflow pulse) any word that arrives while it is blocked.
module deser_out_stage #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 5
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic [LEN_W-1:0]  load_len_i,
   input  logic              rdy_i,
   output logic              val_o,
   output logic [DATA_W-1:0] data_o,
   output logic [LEN_W-1:0]  len_o,
   output logic              overflow_o
);

   logic free_slot;

   // The slot can take a new word if it is empty or is being emptied this cycle.
   always_comb begin
      free_slot = !val_o || rdy_i;
   end

   // Load, hold, release or drop the word; overflow lasts exactly one cycle.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         val_o      <= 1'b0;
         data_o     <= '0;
         len_o      <= '0;
         overflow_o <= 1'b0;
      end else begin
         overflow_o <= 1'b0;
         if (load_i && free_slot) begin
            val_o  <= 1'b1;
            data_o <= load_data_i;
            len_o  <= load_len_i;
         end else if (load_i) begin
            overflow_o <= 1'b1;
         end else if (val_o && rdy_i) begin
            val_o <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/param_deserializer.sv
// Serial-to-parallel deserializer with per-word length, flush and a
// valid/ready output that drops words arriving while the output is blocked.
module param_deserializer
   import deser_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int MSB_FIRST = 1,
   parameter int LEN_W     = $clog2(DATA_W) + 1
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              data_i,
   input  logic              data_val_i,
   input  logic [LEN_W-1:0]  data_len_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic [LEN_W-1:0]  deser_len_o,
   output logic              deser_data_val_o,
   input  logic              deser_data_rdy_i,
   output logic              overflow_o
);

   state_t            state;
   logic [LEN_W-1:0]  bit_cnt;
   logic [LEN_W-1:0]  word_len;
   logic [LEN_W-1:0]  cur_len;
   logic [LEN_W-1:0]  next_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] next_shift;
   logic              first_bit;
   logic              word_done;

   // Work out the word as it would look with this cycle's bit, and whether it ends here.
   always_comb begin
      first_bit  = (state == IDLE) && data_val_i;
      cur_len    = first_bit ? LEN_W'(clamp_len(32'(data_len_i), DATA_W)) : word_len;
      next_cnt   = data_val_i ? bit_cnt + LEN_W'(1) : bit_cnt;
      next_shift = shift_reg;
      if (data_val_i) begin
         if (MSB_FIRST != 0) begin
            next_shift = {shift_reg[DATA_W-2:0], data_i};
         end else begin
            next_shift = shift_reg | (DATA_W'(data_i) << bit_cnt);
         end
      end
      word_done = (data_val_i && (next_cnt == cur_len)) ||
                  (flush_i && ((state == COLLECT) || data_val_i));
   end

   // Collection FSM: gather bits, then clear everything as soon as a word is handed off.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         word_len  <= '0;
         shift_reg <= '0;
      end else if (word_done) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (data_val_i) begin
         state     <= COLLECT;
         bit_cnt   <= next_cnt;
         shift_reg <= next_shift;
         if (first_bit) begin
            word_len <= cur_len;
         end
      end
   end

   deser_out_stage #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_out_stage (
      .clk_i       (clk_i),
      .arstn_i     (arstn_i),
      .load_i      (word_done),
      .load_data_i (next_shift),
      .load_len_i  (next_cnt),
      .rdy_i       (deser_data_rdy_i),
      .val_o       (deser_data_val_o),
      .data_o      (deser_data_o),
      .len_o       (deser_len_o),
      .overflow_o  (overflow_o)
   );

endmodule

// File: tb/tb_param_deserializer.sv
// Scoreboard bench: drives both an MSB-first and an LSB-first deserializer from
// the same serial stream and checks every accepted word and overflow pulse.
module tb_param_deserializer;

   logic        clk   = 1'b0;
   logic        arstn = 1'b0;
   logic        din   = 1'b0;
   logic        dval  = 1'b0;
   logic        flush = 1'b0;
   logic        rdy   = 1'b0;
   logic [4:0]  dlen  = '0;

   logic [15:0] data_m, data_l;
   logic [4:0]  len_m, len_l;
   logic        val_m, val_l, ovf_m, ovf_l;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;
      logic [4:0]  len;
      int          at;
   } exp_t;

   exp_t q_m[$];
   exp_t q_l[$];
   int   ovf_q_m[$];
   int   ovf_q_l[$];

   param_deserializer #(.DATA_W(16), .MSB_FIRST(1)) dut_m (
      .clk_i            (clk),
      .arstn_i          (arstn),
      .data_i           (din),
      .data_val_i       (dval),
      .data_len_i       (dlen),
      .flush_i          (flush),
      .deser_data_o     (data_m),
      .deser_len_o      (len_m),
      .deser_data_val_o (val_m),
      .deser_data_rdy_i (rdy),
      .overflow_o       (ovf_m)
   );

   param_deserializer #(.DATA_W(16), .MSB_FIRST(0)) dut_l (
      .clk_i            (clk),
      .arstn_i          (arstn),
      .data_i           (din),
      .data_val_i       (dval),
      .data_len_i       (dlen),
      .flush_i          (flush),
      .deser_data_o     (data_l),
      .deser_len_o      (len_l),
      .deser_data_val_o (val_l),
      .deser_data_rdy_i (rdy),
      .overflow_o       (ovf_l)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used to check exact output latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic b, input logic [4:0] l,
                                input logic f, input logic r);
      @(posedge clk);
      #1;
      dval  = v;
      din   = b;
      dlen  = l;
      flush = f;
      rdy   = r;
   endtask

   // First listed bit is bits[n-1]; only the first bit carries the real length.
   task automatic sendWord(input logic [15:0] bits, input int n, input logic [4:0] l, input logic r);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(1'b1, bits[i], (i == n - 1) ? l : 5'd3, 1'b0, r);
      end
   endtask

   // Called right after driving the completing bit; timed words must show up one edge later.
   task automatic expectWord(input logic [15:0] dm, input logic [15:0] dl,
                             input logic [4:0] l, input logic timed);
      exp_t e;
      e.len  = l;
      e.at   = timed ? cyc + 1 : -1;
      e.data = dm;
      q_m.push_back(e);
      e.data = dl;
      q_l.push_back(e);
   endtask

   // Monitor: every handshake and every overflow pulse must match the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (val_m && rdy) begin
         if (q_m.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL msb_unexpected_word: got %0h/%0d expected none", data_m, len_m);
         end else begin
            e = q_m.pop_front();
            checkOutput("msb_word", {data_m, len_m}, {e.data, e.len});
            if (e.at >= 0) checkOutput("msb_latency", cyc, e.at);
         end
      end
      if (val_l && rdy) begin
         if (q_l.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL lsb_unexpected_word: got %0h/%0d expected none", data_l, len_l);
         end else begin
            e = q_l.pop_front();
            checkOutput("lsb_word", {data_l, len_l}, {e.data, e.len});
            if (e.at >= 0) checkOutput("lsb_latency", cyc, e.at);
         end
      end
      if (ovf_m) begin
         if (ovf_q_m.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL msb_unexpected_overflow: got 1 expected 0 at cycle %0d", cyc);
         end else begin
            checkOutput("msb_overflow_cycle", cyc, ovf_q_m.pop_front());
         end
      end
      if (ovf_l) begin
         if (ovf_q_l.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL lsb_unexpected_overflow: got 1 expected 0 at cycle %0d", cyc);
         end else begin
            checkOutput("lsb_overflow_cycle", cyc, ovf_q_l.pop_front());
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("msb_reset_outputs", {val_m, data_m, len_m, ovf_m}, '0);
      checkOutput("lsb_reset_outputs", {val_l, data_l, len_l, ovf_l}, '0);
      arstn = 1'b1;

      // Full 16-bit word requested with length 0.
      sendWord(16'hB000, 16, 5'd0, 1'b1);
      expectWord(16'hB000, 16'h000D, 5'd16, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Two 4-bit words back to back.
      sendWord(16'h000C, 4, 5'd4, 1'b1);
      expectWord(16'h000C, 16'h0003, 5'd4, 1'b1);
      sendWord(16'h000C, 4, 5'd4, 1'b1);
      expectWord(16'h000C, 16'h0003, 5'd4, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Partial word closed by a lone flush.
      sendWord(16'h0005, 3, 5'd8, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      expectWord(16'h0005, 16'h0005, 5'd3, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Flush while idle with no data does nothing.
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Flush together with a first bit gives a 1-bit word.
      applyStimulus(1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
      expectWord(16'h0001, 16'h0001, 5'd1, 1'b1);

      // Length-1 words complete on their only bit, back to back.
      applyStimulus(1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
      expectWord(16'h0001, 16'h0001, 5'd1, 1'b1);
      applyStimulus(1'b1, 1'b0, 5'd1, 1'b0, 1'b1);
      expectWord(16'h0000, 16'h0000, 5'd1, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Flush with a valid bit in COLLECT includes that bit.
      applyStimulus(1'b1, 1'b1, 5'd8, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
      expectWord(16'h0006, 16'h0003, 5'd3, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Oversized length clamps to a full word.
      sendWord(16'hFFFF, 16, 5'd20, 1'b1);
      expectWord(16'hFFFF, 16'hFFFF, 5'd16, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Blocked output: first word held, second dropped with overflow.
      sendWord(16'h0002, 2, 5'd2, 1'b0);
      expectWord(16'h0002, 16'h0001, 5'd2, 1'b0);
      sendWord(16'h0003, 2, 5'd2, 1'b0);
      ovf_q_m.push_back(cyc + 1);
      ovf_q_l.push_back(cyc + 1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Blocked output released in the very cycle the next word completes.
      sendWord(16'h0002, 2, 5'd2, 1'b0);
      expectWord(16'h0002, 16'h0001, 5'd2, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
      expectWord(16'h0003, 16'h0003, 5'd2, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Reset in mid-word while a held word is pending.
      sendWord(16'h00A5, 8, 5'd8, 1'b0);
      sendWord(16'h0012, 5, 5'd8, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("msb_held_before_reset", val_m, 1'b1);
      dval  = 1'b0;
      arstn = 1'b0;
      #1;
      checkOutput("msb_outputs_in_reset", {val_m, data_m, len_m, ovf_m}, '0);
      checkOutput("lsb_outputs_in_reset", {val_l, data_l, len_l, ovf_l}, '0);
      #2;
      arstn = 1'b1;
      dval  = 1'b1;
      din   = 1'b1;
      dlen  = 5'd8;
      rdy   = 1'b1;
      sendWord(16'h0016, 7, 5'd3, 1'b1);
      expectWord(16'h0096, 16'h0069, 5'd8, 1'b1);

      repeat (4) applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      checkOutput("scoreboard_drained",
                  q_m.size() + q_l.size() + ovf_q_m.size() + ovf_q_l.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
